// File: rtl/muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : muldiv_pkg                                                   |
// | Description : Shared constants and the state encoding for mul_div_unit.    |
// |               It holds the op encoding, the FSM state enum, the default    |
// |               operand width and the divide-by-zero quotient pattern.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Op select encoding
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Quotient reported on a zero divisor (all ones)
  localparam logic [DEFAULT_WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_DIV   = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : muldiv_step                                                  |
// | Description : Combinational single-iteration datapath for mul_div_unit.   |
// |               MUL: radix-2 Booth add/sub on the upper accumulator half,   |
// |                    then a 1-bit arithmetic shift right of {hi,lo,qm1}.     |
// |               DIV: restoring step; shift {rem,quot} left one bit, trial   |
// |                    subtract the divisor, keep it when non-negative.       |
// | Ports       : op_i   - OP_MUL / OP_DIV                                     |
// |               hi_i   - WIDTH+1 upper accumulator / partial remainder       |
// |               lo_i   - WIDTH lower accumulator (multiplier / quotient)     |
// |               qm1_i  - Booth q(-1) bit (MUL only)                          |
// |               m_i    - multiplicand (MUL) or divisor magnitude (DIV)       |
// |               hi_o, lo_o, qm1_o - next-iteration values                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             op_i,
  input  logic [WIDTH:0]   hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             qm1_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             qm1_o
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           fits;

  // Multiplicand is signed for Booth; divisor is already a magnitude.
  assign m_ext = (op_i == OP_MUL) ? {m_i[WIDTH-1], m_i} : {1'b0, m_i};

  always_comb begin
    hi_o    = hi_i;
    lo_o    = lo_i;
    qm1_o   = qm1_i;
    sum     = hi_i;
    shifted = '0;
    trial   = '0;
    fits    = 1'b0;
    if (op_i == OP_MUL) begin
      case ({lo_i[0], qm1_i})
        2'b01:   sum = hi_i + m_ext;
        2'b10:   sum = hi_i - m_ext;
        default: sum = hi_i;
      endcase
      // The extra top bit keeps -2^(W-1) subtractions from overflowing.
      hi_o  = {sum[WIDTH], sum[WIDTH:1]};
      lo_o  = {sum[0], lo_i[WIDTH-1:1]};
      qm1_o = lo_i[0];
    end else begin
      shifted = {hi_i[WIDTH-1:0], lo_i[WIDTH-1]};
      trial   = shifted - m_ext;
      fits    = (shifted >= m_ext);
      hi_o    = fits ? trial : shifted;
      lo_o    = {lo_i[WIDTH-2:0], fits};
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_div_unit                                                 |
// | Description : Multi-cycle signed multiply / divide unit feeding Zhigh and  |
// |               Zlow. Booth multiply and restoring divide on magnitudes,    |
// |               one bit per cycle, with a sign fix-up cycle at the end.     |
// |               Optional feature macro: MULDIV_OVERFLOW_FLAG_EN adds the    |
// |               'overflow' output.                                          |
// | Ports       : clock, clear_n (sync active-low), start, op, y_in, bus_in,  |
// |               z_high, z_low, busy, done, div_by_zero [, overflow]         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] z_high,
  output logic [WIDTH-1:0] z_low,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
`ifdef MULDIV_OVERFLOW_FLAG_EN
  ,
  output logic             overflow
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             op_q;
  logic [WIDTH:0]   hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             qm1_q;
  logic [WIDTH-1:0] m_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic [WIDTH-1:0] z_high_q;
  logic [WIDTH-1:0] z_low_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic [WIDTH:0]   hi_d;
  logic [WIDTH-1:0] lo_d;
  logic             qm1_d;

  logic [WIDTH-1:0] y_mag;
  logic [WIDTH-1:0] b_mag;

  // Magnitudes; -2^(W-1) maps to 2^(W-1), which is correct read as unsigned.
  assign y_mag = y_in[WIDTH-1] ? -y_in : y_in;
  assign b_mag = bus_in[WIDTH-1] ? -bus_in : bus_in;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op_i  (op_q),
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .qm1_i (qm1_q),
    .m_i   (m_q),
    .hi_o  (hi_d),
    .lo_o  (lo_d),
    .qm1_o (qm1_d)
  );

`ifdef MULDIV_OVERFLOW_FLAG_EN
  logic             ovf_q;
  logic             ovf_div_q;
  logic [WIDTH:0]   prod_top;
  // product[2W-1:W-1] must be all-equal for the product to fit in W bits
  assign prod_top = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
  assign overflow = ovf_q;
`endif

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      hi_q     <= '0;
      lo_q     <= '0;
      qm1_q    <= 1'b0;
      m_q      <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      z_high_q <= '0;
      z_low_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
`ifdef MULDIV_OVERFLOW_FLAG_EN
      ovf_q     <= 1'b0;
      ovf_div_q <= 1'b0;
`endif
    end else begin
      // Status outputs trail the state by one cycle, so done appears the
      // cycle after DONE and busy drops on that same cycle.
      busy_q <= (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIXUP);
      done_q <= (state_q == S_DONE);

      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q <= '0;
            op_q  <= op;
            qm1_q <= 1'b0;
            hi_q  <= '0;
            dbz_q <= 1'b0;
`ifdef MULDIV_OVERFLOW_FLAG_EN
            ovf_q     <= 1'b0;
            ovf_div_q <= (y_in == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus_in);
`endif
            if (op == OP_MUL) begin
              lo_q    <= bus_in;
              m_q     <= y_in;
              state_q <= S_MUL;
            end else if (bus_in == '0) begin
              // Zero divisor: report all-ones quotient and the dividend.
              z_low_q  <= '1;
              z_high_q <= y_in;
              dbz_q    <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              lo_q     <= y_mag;
              m_q      <= b_mag;
              sign_a_q <= y_in[WIDTH-1];
              sign_b_q <= bus_in[WIDTH-1];
              state_q  <= S_DIV;
            end
          end
        end

        S_MUL, S_DIV: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= S_FIXUP;
          end
        end

        S_FIXUP: begin
          if (op_q == OP_MUL) begin
            z_high_q <= hi_q[WIDTH-1:0];
            z_low_q  <= lo_q;
`ifdef MULDIV_OVERFLOW_FLAG_EN
            ovf_q    <= !((&prod_top) || (~|prod_top));
`endif
          end else begin
            z_low_q  <= (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
            z_high_q <= sign_a_q ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
`ifdef MULDIV_OVERFLOW_FLAG_EN
            ovf_q    <= ovf_div_q;
`endif
          end
          state_q <= S_DONE;
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign z_high      = z_high_q;
  assign z_low       = z_low_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire
